// File: rtl/board_pkg.sv
// Board-wide constants shared by the board I/O blocks: clock rate, key FSM
// state encoding and the millisecond-to-cycle conversion.
package board_pkg;

    localparam int unsigned BOARD_CLK_HZ = 50_000_000;

    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    typedef enum logic [1:0] {
        RELEASED     = ST_RELEASED,
        PRESS_WAIT   = ST_PRESS_WAIT,
        PRESSED      = ST_PRESSED,
        RELEASE_WAIT = ST_RELEASE_WAIT
    } key_fsm_e;

    // Divide first so the intermediate product stays within 32 bits on the board clock.
    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
        return clk_hz / 1000 * ms;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, debounce FSM, hold counter and the
// registered press / release / long-press pulses.
module key_debounce_ch
    import board_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = 5,
    parameter int unsigned LONG_CYCLES = 20,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     key_in,
    output logic     key_state,
    output logic     key_press,
    output logic     key_release,
    output logic     key_long,
    output key_fsm_e state_dbg
);

    localparam logic [31:0] DB_LAST   = 32'(DB_CYCLES - 1);
    localparam logic [31:0] LONG_LAST = 32'(LONG_CYCLES - 1);
    localparam logic [31:0] LONG_SAT  = 32'(LONG_CYCLES);

    logic        s1;
    logic        s2;
    logic        pressed;
    key_fsm_e    state;
    logic [31:0] db_cnt;
    logic [31:0] long_cnt;
    logic [31:0] long_next;
    logic        long_fire;

    assign pressed   = s2 ^ ACTIVE_LOW;
    assign state_dbg = state;

    // Hold counter fires once at LONG_CYCLES-1, then parks at LONG_CYCLES so it never fires again.
    always_comb begin
        long_fire = 1'b0;
        long_next = long_cnt;
        if (long_cnt == LONG_LAST) begin
            long_fire = 1'b1;
            long_next = LONG_SAT;
        end else if (long_cnt < LONG_SAT) begin
            long_next = long_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1          <= ACTIVE_LOW;
            s2          <= ACTIVE_LOW;
            state       <= RELEASED;
            db_cnt      <= '0;
            long_cnt    <= '0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            s1          <= key_in;
            s2          <= s1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            case (state)
                RELEASED: begin
                    if (pressed) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed) begin
                        state  <= RELEASED;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state     <= PRESSED;
                        key_state <= 1'b1;
                        key_press <= 1'b1;
                        long_cnt  <= '0;
                    end else begin
                        db_cnt <= db_cnt + 32'd1;
                    end
                end
                PRESSED: begin
                    long_cnt <= long_next;
                    key_long <= long_fire;
                    if (!pressed) begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // An accepted release wins over a long pulse due on the same edge.
                    if (pressed) begin
                        state    <= PRESSED;
                        long_cnt <= long_next;
                        key_long <= long_fire;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= RELEASED;
                        key_state   <= 1'b0;
                        key_release <= 1'b1;
                    end else begin
                        db_cnt   <= db_cnt + 32'd1;
                        long_cnt <= long_next;
                        key_long <= long_fire;
                    end
                end
                default: state <= RELEASED;
            endcase
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Push-button front end: NUM_KEYS independent synchronise-and-debounce
// channels producing a clean level plus press, release and long-press pulses.
module key_debounce
    import board_pkg::*;
#(
    parameter int unsigned CLK_HZ      = BOARD_CLK_HZ,
    parameter int unsigned NUM_KEYS    = 2,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    localparam int unsigned DB_CYCLES   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned LONG_CYCLES = ms_to_cycles(CLK_HZ, LONG_MS);

    if (NUM_KEYS < 1 || DB_CYCLES < 1 || LONG_CYCLES <= DB_CYCLES) begin : g_bad_params
        $error("key_debounce: need NUM_KEYS >= 1, DB_CYCLES >= 1 and LONG_CYCLES > DB_CYCLES");
    end

    // Per-channel FSM state, kept for hierarchical probing only.
    key_fsm_e unused_fsm_state [NUM_KEYS];

    for (genvar i = 0; i < int'(NUM_KEYS); i++) begin : g_ch
        key_debounce_ch #(
            .DB_CYCLES  (DB_CYCLES),
            .LONG_CYCLES(LONG_CYCLES),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .key_in     (key_in[i]),
            .key_state  (key_state[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_long   (key_long[i]),
            .state_dbg  (unused_fsm_state[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: run-length model of the debounce rules checked every
// cycle, plus directed scenarios with hand-computed event edges.
module tb_key_debounce;

    localparam int NK   = 2;
    localparam int DB   = 5;
    localparam int LONG = 20;
    localparam int W    = 4 * NK;
    localparam logic [NK-1:0] REL_PINS = '1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key_in;
    logic [NK-1:0] key_state;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_long;

    key_debounce #(
        .CLK_HZ     (1000),
        .NUM_KEYS   (NK),
        .DEBOUNCE_MS(5),
        .LONG_MS    (20),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [W-1:0]  exp_q[$];
    logic [NK-1:0] pin_q[$];
    int            run   [NK];
    int            age   [NK];
    bit            level [NK];

    int press_cnt[NK], rel_cnt[NK], long_cnt[NK];
    int press_edge[NK], rel_edge[NK], long_edge[NK];

    task automatic model_reset();
        pin_q = {REL_PINS, REL_PINS};
        for (int k = 0; k < NK; k++) begin
            run[k]   = 0;
            age[k]   = 0;
            level[k] = 1'b0;
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < NK; k++) begin
            press_cnt[k] = 0; rel_cnt[k] = 0; long_cnt[k] = 0;
            press_edge[k] = -1; rel_edge[k] = -1; long_edge[k] = -1;
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a level change is accepted on the (DB+1)-th consecutive two-edge-delayed
    // sample that disagrees with the accepted level; long fires LONG edges after the press.
    initial begin
        model_reset();
        forever begin
            logic [NK-1:0] s, p_vec, e_state, e_press, e_rel, e_long;
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                model_reset();
                exp_q.push_back('0);
            end else begin
                s = pin_q.pop_front();
                pin_q.push_back(key_in);
                p_vec = ~s;
                for (int k = 0; k < NK; k++) begin
                    e_press[k] = 1'b0; e_rel[k] = 1'b0; e_long[k] = 1'b0;
                    if (p_vec[k] != level[k]) run[k]++;
                    else run[k] = 0;
                    if (level[k]) age[k]++;
                    if (run[k] == DB + 1) begin
                        level[k] = !level[k];
                        run[k]   = 0;
                        if (level[k]) begin
                            e_press[k] = 1'b1;
                            age[k]     = 0;
                        end else begin
                            e_rel[k] = 1'b1;
                        end
                    end else if (level[k] && age[k] == LONG) begin
                        e_long[k] = 1'b1;
                    end
                    e_state[k] = level[k];
                end
                exp_q.push_back({e_state, e_press, e_rel, e_long});
            end
        end
    end

    // Scoreboard: compare every cycle, away from the active edge, and log DUT events.
    initial begin
        forever begin
            logic [W-1:0] act, exp;
            @(negedge clk);
            #1;
            act = {key_state, key_press, key_release, key_long};
            if (!rst_n) begin
                exp = '0;
                exp_q.delete();
            end else if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
            end else begin
                exp = '0;
            end
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL cycle_cmp edge %0d: got %b expected %b (state,press,release,long)",
                         cyc, act, exp);
            end
            if (rst_n) begin
                for (int k = 0; k < NK; k++) begin
                    if (key_press[k])   begin press_cnt[k]++; press_edge[k] = cyc; end
                    if (key_release[k]) begin rel_cnt[k]++;   rel_edge[k]   = cyc; end
                    if (key_long[k])    begin long_cnt[k]++;  long_edge[k]  = cyc; end
                end
            end
        end
    end

    // driver tasks
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic drive_keys(input logic [NK-1:0] v, output int e0);
        @(negedge clk);
        key_in = v;
        e0 = cyc + 1;
    endtask

    initial begin
        int e0, r0;
        rst_n  = 1'b0;
        key_in = 2'b11;
        clear_counts();
        wait_cycles(3);
        check_int("reset_outputs", int'({key_state, key_press, key_release, key_long}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        wait_cycles(50);
        check_int("idle_pulses", press_cnt[0] + press_cnt[1] + rel_cnt[0] + rel_cnt[1]
                  + long_cnt[0] + long_cnt[1], 0);

        // single press on key 0
        drive_keys(2'b10, e0);
        wait_cycles(12);
        check_int("press_edge", press_edge[0], e0 + 7);
        check_int("press_count", press_cnt[0], 1);
        check_int("press_state", int'(key_state), 1);
        check_int("key1_untouched", press_cnt[1], 0);

        // keep holding: one long pulse 20 edges after the press
        wait_cycles(25);
        check_int("long_count", long_cnt[0], 1);
        check_int("long_delay", long_edge[0] - press_edge[0], 20);

        drive_keys(2'b11, r0);
        wait_cycles(12);
        check_int("release_edge", rel_edge[0], r0 + 7);
        check_int("release_count", rel_cnt[0], 1);
        check_int("release_state", int'(key_state), 0);
        check_int("long_once", long_cnt[0], 1);

        // bounce: low 3, high 1, then low steadily
        clear_counts();
        drive_keys(2'b10, e0);
        wait_cycles(2);
        drive_keys(2'b11, e0);
        drive_keys(2'b10, e0);
        wait_cycles(10);
        check_int("bounce_press_edge", press_edge[0], e0 + 7);
        check_int("bounce_press_count", press_cnt[0], 1);

        // short hold, release with a 2-cycle re-press glitch
        drive_keys(2'b11, r0);
        wait_cycles(1);
        drive_keys(2'b10, r0);
        wait_cycles(1);
        drive_keys(2'b11, r0);
        wait_cycles(12);
        check_int("glitch_release_edge", rel_edge[0], r0 + 7);
        check_int("glitch_release_count", rel_cnt[0], 1);
        check_int("glitch_no_long", long_cnt[0], 0);
        check_int("glitch_no_repress", press_cnt[0], 1);

        // both keys together, then reset mid-hold
        clear_counts();
        drive_keys(2'b00, e0);
        wait_cycles(12);
        check_int("both_press_edge0", press_edge[0], e0 + 7);
        check_int("both_press_edge1", press_edge[1], e0 + 7);
        check_int("both_state", int'(key_state), 3);
        wait_cycles(3);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_int("reset_drops_state", int'(key_state), 0);
        @(negedge clk);
        key_in = 2'b11;
        wait_cycles(2);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(15);
        check_int("reset_no_release", rel_cnt[0] + rel_cnt[1], 0);
        check_int("reset_no_long", long_cnt[0] + long_cnt[1], 0);
        check_int("post_reset_state", int'(key_state), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
